alu_seq: RTL and testbench

//  Parametrised, registered ALU with valid/ready handshakes. It is the successor to the 32-bit combinational ALU.

---
 rtl/alu_seq.sv | 197 +++++++++++++++++++
 tb/tb_alu_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides and an iterative
// shift-add multiplier; results and {ERR,V,C,N,Z} flags are held until consumed.
module alu_seq #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic [4:0]       flags
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] FOUR = WIDTH'(3'd4);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOT  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_ADD4 = 4'b1001;
    localparam logic [3:0] OP_SUB4 = 4'b1010;
    localparam logic [3:0] OP_PASS = 4'b1011;
    localparam logic [3:0] OP_MUL  = 4'b1100;
    localparam logic [3:0] OP_SLT  = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        OUT  = 2'b10
    } state_t;

    state_t               state_r;
    state_t               next_state_s;
    logic                 accept_s;
    logic                 is_mul_s;
    logic [SHW-1:0]       shamt_s;
    logic [WIDTH:0]       wide_s;
    logic [WIDTH-1:0]     alu_res_s;
    logic [4:0]           alu_flags_s;
    logic                 c_s;
    logic                 v_s;
    logic                 err_s;
    logic [2*WIDTH-1:0]   mul_acc_r;
    logic [2*WIDTH-1:0]   mul_mcand_r;
    logic [2*WIDTH-1:0]   mul_sum_s;
    logic [WIDTH-1:0]     mul_mplier_r;
    logic [SHW-1:0]       mul_cnt_r;
    logic [WIDTH-1:0]     res_r;
    logic [4:0]           flags_r;

    // Error results report only ERR; legal results derive Z and N from the value.
    function automatic logic [4:0] pack_flags(input logic err, input logic v,
                                              input logic c, input logic [WIDTH-1:0] r);
        logic [4:0] f;
        if (err) begin
            f = 5'b10000;
        end else begin
            f = {1'b0, v, c, r[WIDTH-1], (r == '0)};
        end
        return f;
    endfunction

    assign shamt_s   = b[SHW-1:0];
    assign is_mul_s  = MUL_EN && (opcode == OP_MUL);
    assign in_ready  = (state_r == IDLE) || ((state_r == OUT) && out_ready);
    assign accept_s  = in_valid && in_ready;
    assign out_valid = (state_r == OUT);
    assign res       = res_r;
    assign flags     = flags_r;
    assign mul_sum_s = mul_acc_r + (mul_mplier_r[0] ? mul_mcand_r : '0);

    // Single-cycle operations and their flags.
    always_comb begin
        alu_res_s = '0;
        c_s       = 1'b0;
        v_s       = 1'b0;
        err_s     = 1'b0;
        wide_s    = '0;
        case (opcode)
            OP_ADD: begin
                wide_s    = {1'b0, a} + {1'b0, b};
                alu_res_s = wide_s[WIDTH-1:0];
                c_s       = wide_s[WIDTH];
                v_s       = (a[WIDTH-1] == b[WIDTH-1]) && (wide_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                wide_s    = {1'b0, a} - {1'b0, b};
                alu_res_s = wide_s[WIDTH-1:0];
                c_s       = wide_s[WIDTH];
                v_s       = (a[WIDTH-1] != b[WIDTH-1]) && (wide_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res_s = a & b;
            OP_OR:   alu_res_s = a | b;
            OP_XOR:  alu_res_s = a ^ b;
            OP_NOT:  alu_res_s = ~a;
            OP_SLL:  alu_res_s = a << shamt_s;
            OP_SRA:  alu_res_s = $unsigned($signed(a) >>> shamt_s);
            OP_SRL:  alu_res_s = a >> shamt_s;
            OP_ADD4: alu_res_s = a + FOUR;
            OP_SUB4: alu_res_s = a - FOUR;
            OP_PASS: alu_res_s = a;
            OP_MUL:  err_s     = ~MUL_EN;
            OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: err_s     = 1'b1;
        endcase
        alu_flags_s = pack_flags(err_s, v_s, c_s, alu_res_s);
    end

    // Next-state decode; an accept in OUT chains straight into the next op.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = is_mul_s ? MUL : OUT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            MUL: begin
                if (mul_cnt_r == SHW'(WIDTH-1)) begin
                    next_state_s = OUT;
                end else begin
                    next_state_s = MUL;
                end
            end
            OUT: begin
                if (accept_s) begin
                    next_state_s = is_mul_s ? MUL : OUT;
                end else if (out_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = OUT;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Result registers and multiplier datapath; the last step registers the product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_r        <= '0;
            flags_r      <= 5'b00000;
            mul_acc_r    <= '0;
            mul_mcand_r  <= '0;
            mul_mplier_r <= '0;
            mul_cnt_r    <= '0;
        end else if (accept_s && is_mul_s) begin
            mul_acc_r    <= '0;
            mul_mcand_r  <= {{WIDTH{1'b0}}, a};
            mul_mplier_r <= b;
            mul_cnt_r    <= '0;
        end else if (accept_s) begin
            res_r   <= alu_res_s;
            flags_r <= alu_flags_s;
        end else if (state_r == MUL) begin
            mul_acc_r    <= mul_sum_s;
            mul_mcand_r  <= mul_mcand_r << 1;
            mul_mplier_r <= mul_mplier_r >> 1;
            mul_cnt_r    <= mul_cnt_r + 1'b1;
            if (mul_cnt_r == SHW'(WIDTH-1)) begin
                res_r   <= mul_sum_s[WIDTH-1:0];
                flags_r <= pack_flags(1'b0, |mul_sum_s[2*WIDTH-1:WIDTH], 1'b0,
                                      mul_sum_s[WIDTH-1:0]);
            end else begin
                res_r   <= res_r;
                flags_r <= flags_r;
            end
        end else begin
            res_r   <= res_r;
            flags_r <= flags_r;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vectors pinned by literals, a transaction-level
// model with a per-cycle compare process for timing, data, flags and in_ready.
module tb_alu_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   opcode = 4'b0000;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] res;
    logic [4:0]   flags;

    alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .flags(flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] r;
        logic [4:0]   f;
        int           due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference behaviour from the operation definitions: returns {flags, res}.
    function automatic logic [36:0] model(input logic [3:0] op, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
        logic [W-1:0] r;
        logic         c, v, err;
        longint       sx, sy, s;
        logic [63:0]  p;
        int           sh;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sh = int'(y % 32);
        r = '0; c = 1'b0; v = 1'b0; err = 1'b0;
        case (op)
            4'd0: begin
                p = 64'(x) + 64'(y); r = p[31:0]; c = p[32];
                s = sx + sy; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd1: begin
                r = x - y; c = (x < y);
                s = sx - sy; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2: r = x & y;
            4'd3: r = x | y;
            4'd4: r = x ^ y;
            4'd5: r = ~x;
            4'd6: r = x << sh;
            4'd7: r = (x >> sh) | (x[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            4'd8: r = x >> sh;
            4'd9: r = x + 32'd4;
            4'd10: r = x - 32'd4;
            4'd11: r = x;
            4'd12: begin
                p = 64'(x) * 64'(y); r = p[31:0]; v = (p[63:32] != 32'h0);
            end
            4'd13: r = (sx < sy) ? 32'd1 : 32'd0;
            default: err = 1'b1;
        endcase
        if (err) return {5'b10000, 32'h0};
        return {1'b0, v, c, r[31], (r == 32'h0), r};
    endfunction

    // Compare process: every cycle checks in_ready, out_valid timing and held data.
    always @(negedge clk) begin
        logic exp_rdy;
        exp_t e;
        logic [36:0] m;
        if (!rst_n) begin
            check("reset_out_valid", out_valid, 1'b0);
        end else begin
            exp_rdy = (q.size() == 0) ||
                      ((q.size() == 1) && (cyc >= q[0].due) && out_ready);
            check("in_ready", in_ready, exp_rdy);
            if ((q.size() > 0) && (cyc >= q[0].due)) begin
                check("out_valid", out_valid, 1'b1);
                check("res", res, q[0].r);
                check("flags", flags, q[0].f);
                if (out_ready || !out_valid) void'(q.pop_front());
            end else begin
                check("out_valid_idle", out_valid, 1'b0);
            end
            if (in_valid && in_ready) begin
                m = model(opcode, a, b);
                e.r = m[31:0];
                e.f = m[36:32];
                e.due = cyc + 1 + ((opcode == 4'b1100) ? W : 0);
                q.push_back(e);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pins the model against a literal, then presents the op until accepted.
    task automatic send(input string name, input logic [3:0] op, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] er, input logic [4:0] ef);
        int t;
        check({"model_", name}, model(op, x, y), {ef, er});
        opcode = op; a = x; b = y; in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout %s: in_ready stayed 0, required 1", name);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, required finish");
        $fatal(1);
    end

    initial begin
        tick(2);
        check("rst_res", res, 32'h0);
        check("rst_flags", flags, 5'b00000);
        rst_n = 1'b1;
        tick(1);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid_rel", out_valid, 1'b0);
        out_ready = 1'b1;

        send("add_carry", 4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'b00101);
        send("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 5'b01010);
        send("sub_borrow", 4'd1, 32'h0, 32'h1, 32'hFFFF_FFFF, 5'b00110);
        send("sub_ovf", 4'd1, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 5'b01000);
        send("and", 4'd2, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 5'b00000);
        send("or", 4'd3, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF, 5'b00000);
        send("not", 4'd5, 32'h0, 32'h0, 32'hFFFF_FFFF, 5'b00010);
        send("sra31", 4'd7, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 5'b00010);
        send("srl31", 4'd8, 32'h8000_0000, 32'd31, 32'h0000_0001, 5'b00000);
        send("sll0", 4'd6, 32'h1, 32'd0, 32'h1, 5'b00000);
        send("sll31", 4'd6, 32'h1, 32'd31, 32'h8000_0000, 5'b00010);
        send("sll_hi_b", 4'd6, 32'h1, 32'h0000_0123, 32'h8, 5'b00000);
        send("slt", 4'd13, 32'hFFFF_FFFF, 32'h1, 32'h1, 5'b00000);
        send("slt_no", 4'd13, 32'h1, 32'hFFFF_FFFF, 32'h0, 5'b00001);
        send("add4", 4'd9, 32'hFFFF_FFFE, 32'h0, 32'h2, 5'b00000);
        send("sub4", 4'd10, 32'h2, 32'h0, 32'hFFFF_FFFE, 5'b00010);
        send("pass", 4'd11, 32'h0, 32'h5, 32'h0, 5'b00001);
        send("illegal_e", 4'd14, 32'h5, 32'h5, 32'h0, 5'b10000);
        tick(3);

        send("mul_ovf", 4'd12, 32'h0001_0000, 32'h0001_0000, 32'h0, 5'b01001);
        tick(35);
        send("mul_max", 4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 5'b01000);
        tick(35);

        send("b2b_1", 4'd0, 32'd1, 32'd1, 32'd2, 5'b00000);
        send("b2b_2", 4'd0, 32'd2, 32'd2, 32'd4, 5'b00000);
        send("b2b_3", 4'd0, 32'd3, 32'd3, 32'd6, 5'b00000);
        tick(3);

        out_ready = 1'b0;
        send("xor_bp", 4'd4, 32'h0000_00F0, 32'h0000_00FF, 32'h0000_000F, 5'b00000);
        opcode = 4'd0; a = 32'd5; b = 32'd6; in_valid = 1'b1;
        tick(5);
        out_ready = 1'b1;
        send("add_after_bp", 4'd0, 32'd5, 32'd6, 32'd11, 5'b00000);
        tick(3);

        send("mul_reset", 4'd12, 32'd3, 32'd5, 32'd15, 5'b00000);
        tick(9);
        rst_n = 1'b0;
        q.delete();
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("post_rst_in_ready", in_ready, 1'b1);
        check("post_rst_res", res, 32'h0);
        tick(40);
        send("illegal_f", 4'd15, 32'h1234, 32'h5678, 32'h0, 5'b10000);
        send("mul_small", 4'd12, 32'd3, 32'd5, 32'd15, 5'b00000);
        tick(36);
        check("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
